sram_uart_ctrl: RTL and testbench

- Serial-controlled driver for an asynchronous byte-wide SRAM.
- A host sends 6-byte command frames over a UART RX line. The block decodes each frame, runs the matching SRAM write, read or fill cycles, and returns read data on a UART TX line.
- It is the top-level control block between the board UART pins and the SRAM pins.

---
 rtl/sram_uart_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_sram_uart_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_uart_ctrl.sv
// UART-commanded controller for an asynchronous byte-wide SRAM.
// Decodes 6-byte frames (CMD, ARG[31:0], 0x00), runs write/read/fill cycles and returns read data over UART TX.
module sram_uart_ctrl #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 16,
    parameter int WR_CYCLES    = 2,
    parameter int RD_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx,
    output logic              tx,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_data_write,
    input  logic [7:0]        sram_data_read,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              busy
);
    localparam int CW = 16;
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] IDLE_LIMIT = CW'(16 * CLKS_PER_BIT);
    localparam logic [CW-1:0] WR_LAST    = CW'(WR_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST    = CW'(RD_CYCLES - 1);

    localparam logic [7:0] CMD_ADDR  = 8'h01;
    localparam logic [7:0] CMD_LOAD  = 8'h02;
    localparam logic [7:0] CMD_WRITE = 8'h03;
    localparam logic [7:0] CMD_READ  = 8'h04;
    localparam logic [7:0] CMD_RDREQ = 8'h05;
    localparam logic [7:0] CMD_COUNT = 8'h06;
    localparam logic [7:0] CMD_CONST = 8'h07;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {S_IDLE, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_WR_GAP, S_RD, S_TX} state_e;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_vld;
    logic [2:0]      byte_idx_q, byte_idx_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [31:0]     arg_q, arg_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            go_q, go_d;

    state_e          state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      read_q, read_d;
    logic [31:0]     rem_q, rem_d;
    logic            fill_q, fill_d;
    logic            count_q, count_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [9:0]      tx_frame;

    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            data_oe_q, data_oe_d;
    logic            ce_n_q, ce_n_d;
    logic            we_n_q, we_n_d;
    logic            oe_n_q, oe_n_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    // RX byte receiver and frame parser next-state logic
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_vld   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = 3'd0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
                else                         rx_state_d = RX_IDLE;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_state_d = RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    byte_vld   = rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        byte_idx_d = byte_idx_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        idle_cnt_d = idle_cnt_q;
        go_d       = 1'b0;
        if (byte_vld) begin
            idle_cnt_d = '0;
            case (byte_idx_q)
                3'd0: begin
                    cmd_d      = rx_shift_q;
                    byte_idx_d = 3'd1;
                end
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    arg_d      = {arg_q[23:0], rx_shift_q};
                    byte_idx_d = byte_idx_q + 3'd1;
                end
                3'd5: begin
                    byte_idx_d = 3'd0;
                    go_d       = (rx_shift_q == 8'h00) && !busy_q;
                end
                default: byte_idx_d = 3'd0;
            endcase
        end else if (byte_idx_q == 3'd0 || rx_state_q != RX_IDLE) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LIMIT) begin
            // A stalled partial frame is abandoned so the next byte is taken as a command.
            idle_cnt_d = '0;
            byte_idx_d = 3'd0;
        end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
        end
    end

    // Command sequencer next-state logic and registered SRAM/TX output values
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        read_d   = read_q;
        rem_d    = rem_q;
        fill_d   = fill_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        tx_bit_d = tx_bit_q;
        tx_frame = {1'b1, read_q, 1'b0};
        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                tx_bit_d = 4'd0;
                if (go_q) begin
                    case (cmd_q)
                        CMD_ADDR:  addr_d = arg_q[ADDR_W-1:0];
                        CMD_LOAD:  data_d = arg_q[7:0];
                        CMD_WRITE: begin
                            rem_d   = 32'd1;
                            fill_d  = 1'b0;
                            count_d = 1'b0;
                            state_d = S_WR_SETUP;
                        end
                        CMD_READ:  state_d = S_TX;
                        CMD_RDREQ: state_d = S_RD;
                        CMD_COUNT, CMD_CONST: begin
                            if (arg_q != 32'd0) begin
                                rem_d   = arg_q;
                                fill_d  = 1'b1;
                                count_d = (cmd_q == CMD_COUNT);
                                state_d = S_WR_SETUP;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_SETUP: begin
                cnt_d   = '0;
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt_q == WR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR_HOLD: begin
                rem_d = rem_q - 32'd1;
                if (fill_q) addr_d = addr_q + ADDR_W'(1);
                else        addr_d = addr_q;
                state_d = (rem_q == 32'd1) ? S_IDLE : S_WR_GAP;
            end
            S_WR_GAP: state_d = S_WR_SETUP;
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    cnt_d   = '0;
                    read_d  = sram_data_read;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TX: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_bit_d = 4'd0;
                        state_d  = S_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        if (state_d == S_WR_SETUP) begin
            sram_addr_d = addr_q;
            wdata_d     = count_d ? addr_q[7:0] : data_q;
        end else if (state_d == S_RD) begin
            sram_addr_d = addr_q;
        end else begin
            sram_addr_d = sram_addr_q;
        end
        data_oe_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
        ce_n_d    = !(data_oe_d || (state_d == S_RD));
        we_n_d    = (state_d != S_WR_PULSE);
        oe_n_d    = (state_d != S_RD);
        busy_d    = (state_d != S_IDLE);
        tx_d      = (state_d == S_TX) ? tx_frame[tx_bit_d] : 1'b1;
    end

    // State and output registers; reset aborts any frame or SRAM cycle at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
            byte_idx_q  <= 3'd0;
            cmd_q       <= 8'h00;
            arg_q       <= 32'd0;
            idle_cnt_q  <= '0;
            go_q        <= 1'b0;
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= 8'h00;
            read_q      <= 8'h00;
            rem_q       <= 32'd0;
            fill_q      <= 1'b0;
            count_q     <= 1'b0;
            cnt_q       <= '0;
            tx_bit_q    <= 4'd0;
            sram_addr_q <= '0;
            wdata_q     <= 8'h00;
            data_oe_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            byte_idx_q  <= byte_idx_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            idle_cnt_q  <= idle_cnt_d;
            go_q        <= go_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            read_q      <= read_d;
            rem_q       <= rem_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            tx_bit_q    <= tx_bit_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            data_oe_q   <= data_oe_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign tx              = tx_q;
    assign sram_addr       = sram_addr_q;
    assign sram_data_write = wdata_q;
    assign sram_data_oe    = data_oe_q;
    assign sram_ce_n       = ce_n_q;
    assign sram_we_n       = we_n_q;
    assign sram_oe_n       = oe_n_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_sram_uart_ctrl.sv
// Scoreboard bench for sram_uart_ctrl: drives UART frames, predicts SRAM cycles and TX bytes, compares on DUT activity.
module tb_sram_uart_ctrl;
    localparam int C = 16;

    logic        clk;
    logic        rstn;
    logic        rx;
    logic        tx;
    logic [15:0] sram_addr;
    logic [7:0]  sram_data_write;
    logic [7:0]  sram_data_read;
    logic        sram_data_oe;
    logic        sram_ce_n;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        busy;

    sram_uart_ctrl #(.CLKS_PER_BIT(C), .ADDR_W(16), .WR_CYCLES(2), .RD_CYCLES(2)) dut (
        .clk(clk), .rstn(rstn), .rx(rx), .tx(tx),
        .sram_addr(sram_addr), .sram_data_write(sram_data_write), .sram_data_read(sram_data_read),
        .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] wq[$];
    logic [15:0] rq[$];
    logic [7:0]  tq[$];

    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  m_data = 8'h00;
    logic [7:0]  m_read = 8'h00;

    logic        fill_mode = 1'b0;
    logic [15:0] fill_base = 16'h0000;
    logic [7:0]  fill_data = 8'h00;
    int          fill_k    = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // SRAM cycle monitor: collects one ce_n-low window and checks it against the scoreboard
    logic        win_open = 1'b0;
    logic        win_wr, win_bad, first_we, last_we;
    int          we_cnt, oe_cnt;
    logic [15:0] w_addr;
    logic [7:0]  w_data;
    logic [23:0] e_wr;
    logic [15:0] e_rd;
    always @(negedge clk) begin
        if (!rstn) begin
            win_open = 1'b0;
        end else if (!sram_ce_n) begin
            if (!win_open) begin
                win_open = 1'b1;
                win_wr   = sram_data_oe;
                win_bad  = 1'b0;
                we_cnt   = 0;
                oe_cnt   = 0;
                w_addr   = sram_addr;
                w_data   = sram_data_write;
                first_we = sram_we_n;
            end
            if (!sram_we_n) we_cnt++;
            if (!sram_oe_n) oe_cnt++;
            if (sram_addr !== w_addr) win_bad = 1'b1;
            if (win_wr && sram_data_write !== w_data) win_bad = 1'b1;
            if (!sram_we_n && !sram_oe_n) win_bad = 1'b1;
            if (sram_data_oe !== win_wr) win_bad = 1'b1;
            last_we = sram_we_n;
        end else if (win_open) begin
            win_open = 1'b0;
            check_eq("bus_rules", 32'(win_bad), 32'd0);
            if (win_wr) begin
                check_eq("we_len", 32'(we_cnt), 32'd2);
                check_eq("wr_setup_hold", {30'd0, first_we, last_we}, 32'd3);
                check_eq("wr_no_oe", 32'(oe_cnt), 32'd0);
                if (fill_mode) begin
                    check_eq("fill_addr", 32'(w_addr), 32'(fill_base + 16'(fill_k)));
                    check_eq("fill_data", 32'(w_data), 32'(fill_data));
                    fill_k++;
                end else if (wq.size() == 0) begin
                    check_eq("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e_wr = wq.pop_front();
                    check_eq("wr_addr", 32'(w_addr), 32'(e_wr[23:8]));
                    check_eq("wr_data", 32'(w_data), 32'(e_wr[7:0]));
                end
            end else begin
                check_eq("oe_len", 32'(oe_cnt), 32'd2);
                check_eq("rd_no_we", 32'(we_cnt), 32'd0);
                if (rq.size() == 0) begin
                    check_eq("unexpected_read", 32'd1, 32'd0);
                end else begin
                    e_rd = rq.pop_front();
                    check_eq("rd_addr", 32'(w_addr), 32'(e_rd));
                end
            end
        end
    end

    // TX monitor: decodes each 8N1 byte at mid-bit and compares it with the scoreboard
    initial begin
        logic [7:0] b;
        logic       s_start, s_stop;
        forever begin
            @(negedge clk);
            if (rstn && tx === 1'b0) begin
                repeat (C / 2 - 1) @(negedge clk);
                s_start = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = tx;
                end
                repeat (C) @(negedge clk);
                s_stop = tx;
                check_eq("tx_start", 32'(s_start), 32'd0);
                check_eq("tx_stop", 32'(s_stop), 32'd1);
                if (tq.size() == 0) check_eq("unexpected_tx", 32'd1, 32'd0);
                else                check_eq("tx_byte", 32'(b), 32'(tq.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop_lvl;
        repeat (C) @(negedge clk);
        rx = 1'b1;
        if (!stop_lvl) repeat (C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] arg,
                              input logic [7:0] term, input logic bad_stop);
        send_byte(cmd, 1'b1);
        send_byte(arg[31:24], 1'b1);
        send_byte(arg[23:16], 1'b1);
        send_byte(arg[15:8], 1'b1);
        send_byte(arg[7:0], 1'b1);
        send_byte(term, !bad_stop);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq("busy_clear", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_addr(input logic [15:0] a);
        m_addr = a;
        send_frame(8'h01, {16'h0000, a}, 8'h00, 1'b0);
        wait_idle();
    endtask

    task automatic do_load(input logic [7:0] d);
        m_data = d;
        send_frame(8'h02, {24'h000000, d}, 8'h00, 1'b0);
        wait_idle();
    endtask

    task automatic do_write();
        wq.push_back({m_addr, m_data});
        send_frame(8'h03, 32'd0, 8'h00, 1'b0);
        wait_idle();
    endtask

    task automatic do_rdreq();
        rq.push_back(m_addr);
        m_read = sram_data_read;
        send_frame(8'h05, 32'd0, 8'h00, 1'b0);
        wait_idle();
    endtask

    task automatic do_read();
        tq.push_back(m_read);
        send_frame(8'h04, 32'd0, 8'h00, 1'b0);
        wait_idle();
    endtask

    task automatic do_count(input int n);
        for (int i = 0; i < n; i++) begin
            wq.push_back({m_addr, m_addr[7:0]});
            m_addr = m_addr + 16'd1;
        end
        send_frame(8'h06, 32'(n), 8'h00, 1'b0);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx"},      32'(tx), 32'd1);
        check_eq({tag, "_ce_n"},    32'(sram_ce_n), 32'd1);
        check_eq({tag, "_we_n"},    32'(sram_we_n), 32'd1);
        check_eq({tag, "_oe_n"},    32'(sram_oe_n), 32'd1);
        check_eq({tag, "_data_oe"}, 32'(sram_data_oe), 32'd0);
        check_eq({tag, "_addr"},    32'(sram_addr), 32'd0);
        check_eq({tag, "_wdata"},   32'(sram_data_write), 32'd0);
        check_eq({tag, "_busy"},    32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        rx = 1'b1;
        sram_data_read = 8'h00;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        do_addr(16'h0001);
        do_load(8'h01);
        do_write();

        sram_data_read = 8'h5A;
        do_addr(16'h0001);
        do_rdreq();
        do_read();

        sram_data_read = 8'h00;
        do_rdreq();
        do_read();

        do_addr(16'hFFFE);
        do_count(4);
        do_load(8'h77);
        do_write();
        check_eq("addr_held_idle", 32'(sram_addr), 32'h0002);

        send_frame(8'h03, 32'd0, 8'h55, 1'b0);
        wait_idle();
        send_frame(8'h03, 32'd0, 8'h00, 1'b1);
        repeat (20 * C) @(negedge clk);
        do_load(8'h3C);
        do_write();

        do_addr(16'h0100);
        do_load(8'hA5);
        fill_base = 16'h0100;
        fill_data = 8'hA5;
        fill_k = 0;
        fill_mode = 1'b1;
        send_frame(8'h07, 32'd100, 8'h00, 1'b0);
        n = 0;
        while (fill_k < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (sram_we_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("fill_in_pulse", 32'(sram_we_n), 32'd0);
        #1 rstn = 1'b0;
        #1 check_reset_outputs("midreset");
        check_eq("fill_aborted", 32'(fill_k < 100), 32'd1);
        repeat (3) @(negedge clk);
        fill_mode = 1'b0;
        m_addr = 16'h0000;
        m_data = 8'h00;
        m_read = 8'h00;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("post_reset_idle_ce", 32'(sram_ce_n), 32'd1);

        do_addr(16'h0010);
        do_load(8'h42);
        do_write();

        n = 0;
        while ((wq.size() != 0 || rq.size() != 0 || tq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2 * C) @(negedge clk);
        check_eq("wq_drained", 32'(wq.size()), 32'd0);
        check_eq("rq_drained", 32'(rq.size()), 32'd0);
        check_eq("tq_drained", 32'(tq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
